// File: rtl/pit_bus_sequencer_if.sv
// pit_bus_sequencer_if: request fields, status and 8254 bus pins
// shared between the sequencer and its requester.
interface pit_bus_sequencer_if;
  logic        req;
  logic        op;
  logic [1:0]  chan;
  logic [1:0]  rw;
  logic [2:0]  mode;
  logic        bcd;
  logic [15:0] count;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rd_value;
  logic        cs_n;
  logic        wr_n;
  logic        rd_n;
  logic        a1;
  logic        a0;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (
    output req, op, chan, rw, mode, bcd, count, data_in,
    input  busy, done, err, rd_value,
    input  cs_n, wr_n, rd_n, a1, a0, data_out, data_oe
  );

  modport slave (
    input  req, op, chan, rw, mode, bcd, count, data_in,
    output busy, done, err, rd_value,
    output cs_n, wr_n, rd_n, a1, a0, data_out, data_oe
  );
endinterface

// File: rtl/pit_bus_sequencer.sv
// pit_bus_sequencer: turns program / latch-read requests into
// 8254 PIT bus cycles (control word, then data bytes).
module pit_bus_sequencer #(
  parameter int WR_WIDTH = 2,
  parameter int GAP      = 1
) (
  input logic                clk,
  input logic                rst_n,
  pit_bus_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_GAPW   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] WR_LAST = 4'(WR_WIDTH - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP > 0) ? GAP - 1 : 0);

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [3:0]  tmr;
  logic        op_q;
  logic [1:0]  chan_q;
  logic [1:0]  rw_q;
  logic [2:0]  mode_q;
  logic        bcd_q;
  logic [15:0] cnt_q;
  logic [7:0]  lsb_q;
  logic [7:0]  msb_q;
  logic [15:0] rd_q;
  logic        err_q;

  logic        illegal;
  logic        cur_rd;
  logic        use_msb;
  logic        active;
  logic [1:0]  last_idx;
  logic [1:0]  cur_addr;
  logic [7:0]  ctrl_byte;
  logic [7:0]  cur_data;

  assign illegal  = (bus.chan == 2'd3) ||
                    (!bus.op && bus.rw == 2'b00);
  assign cur_rd   = op_q && (idx != 2'd0);
  assign last_idx = (op_q || rw_q == 2'b11) ? 2'd2 : 2'd1;
  assign cur_addr = (idx == 2'd0) ? 2'b11 : chan_q;
  // A lone MSB write is the second byte, not the third.
  assign use_msb  = (idx == 2'd2) ||
                    (idx == 2'd1 && rw_q == 2'b10);
  assign active   = (state == S_SETUP) ||
                    (state == S_STROBE) ||
                    (state == S_HOLD);

  always_comb begin
    ctrl_byte = op_q ? {chan_q, 6'b0}
                     : {chan_q, rw_q, mode_q, bcd_q};
    unique case (1'b1)
      idx == 2'd0: cur_data = ctrl_byte;
      use_msb:     cur_data = cnt_q[15:8];
      default:     cur_data = cnt_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      tmr    <= 4'd0;
      op_q   <= 1'b0;
      chan_q <= 2'd0;
      rw_q   <= 2'd0;
      mode_q <= 3'd0;
      bcd_q  <= 1'b0;
      cnt_q  <= 16'd0;
      lsb_q  <= 8'd0;
      msb_q  <= 8'd0;
      rd_q   <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              op_q   <= bus.op;
              chan_q <= bus.chan;
              rw_q   <= bus.rw;
              mode_q <= bus.mode;
              bcd_q  <= bus.bcd;
              cnt_q  <= bus.count;
              idx    <= 2'd0;
              state  <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          tmr   <= WR_LAST;
          state <= S_STROBE;
        end
        S_STROBE: begin
          if (tmr == 4'd0) begin
            if (cur_rd) begin
              if (idx == 2'd1) lsb_q <= bus.data_in;
              else             msb_q <= bus.data_in;
            end
            state <= S_HOLD;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        S_HOLD: begin
          if (idx == last_idx) begin
            if (op_q) rd_q <= {msb_q, lsb_q};
            state <= S_DONE;
          end else begin
            idx <= idx + 2'd1;
            if (GAP == 0) begin
              state <= S_SETUP;
            end else begin
              tmr   <= GAP_LAST;
              state <= S_GAPW;
            end
          end
        end
        S_GAPW: begin
          if (tmr == 4'd0) state <= S_SETUP;
          else             tmr   <= tmr - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = err_q;
  assign bus.rd_value = rd_q;
  assign bus.cs_n     = !active;
  assign bus.wr_n     = !(state == S_STROBE && !cur_rd);
  assign bus.rd_n     = !(state == S_STROBE && cur_rd);
  assign bus.a1       = active ? cur_addr[1] : 1'b0;
  assign bus.a0       = active ? cur_addr[0] : 1'b0;
  assign bus.data_out = (active && !cur_rd) ? cur_data : 8'd0;
  assign bus.data_oe  = active && !cur_rd;
endmodule

// File: tb/tb_pit_bus_sequencer.sv
// tb_pit_bus_sequencer: random and directed ops on two parameter
// sets, checked against a per-clock bus schedule model.
module tb_pit_bus_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        op = 1'b0;
  logic        bcd = 1'b0;
  logic [1:0]  chan = 2'd0;
  logic [1:0]  rw = 2'd0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] cnt = 16'd0;
  logic [7:0]  din = 8'd0;
  int          sel = 0;

  pit_bus_sequencer_if ia();
  pit_bus_sequencer_if ib();

  assign ia.req = req && (sel == 0);
  assign ib.req = req && (sel == 1);
  assign ia.op = op;
  assign ib.op = op;
  assign ia.chan = chan;
  assign ib.chan = chan;
  assign ia.rw = rw;
  assign ib.rw = rw;
  assign ia.mode = mode;
  assign ib.mode = mode;
  assign ia.bcd = bcd;
  assign ib.bcd = bcd;
  assign ia.count = cnt;
  assign ib.count = cnt;
  assign ia.data_in = din;
  assign ib.data_in = din;

  pit_bus_sequencer #(.WR_WIDTH(2), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  pit_bus_sequencer #(.WR_WIDTH(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  // ctl = {busy, done, err, cs_n, wr_n, rd_n, data_oe}
  wire [6:0] ctl_a = {ia.busy, ia.done, ia.err, ia.cs_n,
                      ia.wr_n, ia.rd_n, ia.data_oe};
  wire [6:0] ctl_b = {ib.busy, ib.done, ib.err, ib.cs_n,
                      ib.wr_n, ib.rd_n, ib.data_oe};
  wire [6:0]  ctl = (sel == 1) ? ctl_b : ctl_a;
  wire [1:0]  adr = (sel == 1) ? {ib.a1, ib.a0} : {ia.a1, ia.a0};
  wire [7:0]  dout = (sel == 1) ? ib.data_out : ia.data_out;
  wire [15:0] rdv = (sel == 1) ? ib.rd_value : ia.rd_value;

  localparam logic [6:0] IDLE_CTL = 7'b0001110;

  int nvec = 0;
  int nmis = 0;
  logic [15:0] last_rd [2];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic scramble(bit allow_req);
    req  = allow_req ? 1'($urandom) : 1'b0;
    op   = 1'($urandom);
    chan = 2'($urandom);
    rw   = 2'($urandom);
    mode = 3'($urandom);
    bcd  = 1'($urandom);
    cnt  = 16'($urandom);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_ctl"}, 32'(ctl), 32'(IDLE_CTL));
    chk({tag, "_adr"}, 32'(adr), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_rdv"}, 32'(rdv), 32'd0);
  endtask

  task automatic run_op(bit o, logic [1:0] c, logic [1:0] m_rw,
                        logic [2:0] m_md, bit m_bcd,
                        logic [15:0] m_cnt, logic [7:0] lv,
                        logic [7:0] mv, int abort_at);
    int w, g, p, nb, dclk, last_k, b, of;
    logic [7:0] dat [3];
    logic [1:0] ad [3];
    bit isw [3];
    bit bad, act;
    logic [6:0] ec;
    w = (sel == 1) ? 1 : 2;
    g = (sel == 1) ? 0 : 1;
    p = w + 2 + g;
    bad = (c == 2'd3) || (!o && m_rw == 2'd0);
    for (int i = 0; i < 3; i++) begin
      dat[i] = 8'd0; ad[i] = 2'd0; isw[i] = 1'b0;
    end
    ad[0] = 2'b11;
    isw[0] = 1'b1;
    dat[0] = o ? {c, 6'b0} : {c, m_rw, m_md, m_bcd};
    nb = 1;
    if (o) begin
      ad[1] = c; ad[2] = c;
      nb = 3;
    end else begin
      if (m_rw[0]) begin
        ad[nb] = c; isw[nb] = 1'b1; dat[nb] = m_cnt[7:0]; nb++;
      end
      if (m_rw[1]) begin
        ad[nb] = c; isw[nb] = 1'b1; dat[nb] = m_cnt[15:8]; nb++;
      end
    end
    dclk = 1 + (nb - 1) * p + w + 2;
    last_k = bad ? 2 : dclk + 1;

    @(negedge clk);
    req = 1'b1; op = o; chan = c; rw = m_rw;
    mode = m_md; bcd = m_bcd; cnt = m_cnt;
    din = 8'($urandom);

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      act = 1'b0;
      b = 0;
      if (bad) begin
        ec = (k == 1) ? 7'b0011110 : IDLE_CTL;
        chk("err_ctl", 32'(ctl), 32'(ec));
        chk("err_rdv", 32'(rdv), 32'(last_rd[sel]));
      end else if (k == dclk) begin
        chk("done_ctl", 32'(ctl), 32'(7'b1101110));
        if (o) last_rd[sel] = {mv, lv};
        chk("done_rdv", 32'(rdv), 32'(last_rd[sel]));
      end else if (k > dclk) begin
        chk("post_ctl", 32'(ctl), 32'(IDLE_CTL));
      end else begin
        b = (k - 1) / p;
        of = (k - 1) % p;
        if (of < w + 2) begin
          act = 1'b1;
          ec = {3'b100, 1'b0,
                !(isw[b] && of >= 1 && of <= w),
                !(!isw[b] && of >= 1 && of <= w),
                isw[b]};
          chk("bus_ctl", 32'(ctl), 32'(ec));
          chk("bus_adr", 32'(adr), 32'(ad[b]));
          if (isw[b]) chk("bus_dat", 32'(dout), 32'(dat[b]));
        end else begin
          chk("gap_ctl", 32'(ctl), 32'(7'b1001110));
        end
      end
      scramble(!bad && k < dclk);
      if (act && !isw[b]) din = (b == 1) ? lv : mv;
      else                din = 8'($urandom);
      if (k == abort_at) begin
        req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        last_rd[0] = 16'd0;
        last_rd[1] = 16'd0;
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("abort_idle", 32'(ctl), 32'(IDLE_CTL));
        end
        return;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    last_rd[0] = 16'd0;
    last_rd[1] = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0;
    check_reset_state("rst_a");
    sel = 1;
    check_reset_state("rst_b");
    rst_n = 1'b1;

    sel = 0;
    run_op(1'b0, 2'd0, 2'b11, 3'b010, 1'b0, 16'h1234, 0, 0, 0);
    run_op(1'b0, 2'd2, 2'b01, 3'b001, 1'b0, 16'h0005, 0, 0, 0);
    run_op(1'b1, 2'd1, 2'b00, 3'b000, 1'b0, 16'h0000,
           8'hCD, 8'hAB, 0);
    run_op(1'b0, 2'd1, 2'b10, 3'b011, 1'b1, 16'hBEEF, 0, 0, 0);
    run_op(1'b0, 2'd3, 2'b11, 3'b000, 1'b0, 16'h1111, 0, 0, 0);
    run_op(1'b0, 2'd1, 2'b00, 3'b000, 1'b0, 16'h2222, 0, 0, 0);
    run_op(1'b0, 2'd0, 2'b11, 3'b100, 1'b0, 16'h5A5A, 0, 0, 7);
    run_op(1'b1, 2'd2, 2'b01, 3'b000, 1'b0, 16'h0000,
           8'h11, 8'h22, 0);

    sel = 1;
    run_op(1'b0, 2'd1, 2'b10, 3'b000, 1'b0, 16'h7700, 0, 0, 0);
    run_op(1'b1, 2'd0, 2'b11, 3'b000, 1'b0, 16'h0000,
           8'h3C, 8'hC3, 0);
    run_op(1'b0, 2'd0, 2'b11, 3'b101, 1'b1, 16'h9876, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 1));
      run_op(1'($urandom), 2'($urandom), 2'($urandom),
             3'($urandom), 1'($urandom), 16'($urandom),
             8'($urandom), 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pit_bus_sequencer.md
PIT_BUS_SEQUENCER -- requirements
Module: pit_bus_sequencer

Interface
REQ-001 Parameter WR_WIDTH, default 2: strobe (wr_n/rd_n) low width in clocks, legal 1..15.
REQ-002 Parameter GAP, default 1: idle clocks with cs_n high between consecutive bus cycles of one operation, legal 0..15.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  single rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req  in  1  operation request, sampled only in IDLE.
REQ-007 op  in  1  0 = program counter, 1 = latch-and-read counter.
REQ-008 chan  in  2  target counter 0..2.
REQ-009 rw  in  2  access mode: 01 LSB, 10 MSB, 11 LSB then MSB.
REQ-010 mode  in  3  counter mode field for the control word.
REQ-011 bcd  in  1  BCD bit for the control word.
REQ-012 count  in  16  initial count for program ops.
REQ-013 data_in  in  8  8254 data bus read value.
REQ-014 busy  out  1  operation in progress.
REQ-015 done  out  1  one-clock completion pulse.
REQ-016 err  out  1  one-clock illegal-request pulse.
REQ-017 rd_value  out  16  last read-back count, {MSB,LSB}.
REQ-018 cs_n, wr_n, rd_n  out  1 each  8254 bus strobes, active low.
REQ-019 a1, a0  out  1 each  8254 address.
REQ-020 data_out  out  8  write data; data_oe  out  1  drive-enable for data_out.

Function
REQ-021 States: IDLE, SETUP, STROBE, HOLD, GAPW, DONE; a byte index selects the current bus cycle.
REQ-022 In IDLE with req=1, all request fields SHALL be captured; later input changes are ignored until IDLE.
REQ-023 Illegal request (chan=3, or op=0 with rw=00): err=1 next clock, no bus activity, no done, stay IDLE.
REQ-024 Program op byte list: control word {chan,rw,mode,bcd} to A1A0=11; then LSB count[7:0] if rw[0]; then MSB count[15:8] if rw[1]; data bytes go to A1A0=chan.
REQ-025 Read op byte list: latch command {chan,00,0000} to A1A0=11; read LSB then MSB from A1A0=chan; rw, mode, bcd ignored.
REQ-026 SETUP, 1 clock: cs_n=0, address valid, data_out valid and data_oe=1 for writes only, wr_n=rd_n=1.
REQ-027 STROBE, WR_WIDTH clocks: wr_n=0 (write) or rd_n=0 (read); address/data held.
REQ-028 Reads SHALL sample data_in on the last STROBE clock.
REQ-029 HOLD, 1 clock: strobes high, cs_n=0, address/data held.
REQ-030 GAPW, GAP clocks (skipped if GAP=0 or after the last byte): cs_n=1, data_oe=0.
REQ-031 After the last HOLD: DONE for 1 clock with done=1, busy=1; rd_value updated in that clock for reads; then IDLE.
REQ-032 busy=1 from the clock after acceptance through DONE; req while busy is dropped, not queued.
REQ-033 wr_n and rd_n SHALL never be low together; neither is low while cs_n=1.
REQ-034 Latency, WR_WIDTH=2, GAP=1, rw=11, req accepted at edge 0: SETUP at clock 1, cycles 1-4, 6-9, 11-14, done at clock 15.
REQ-035 rd_value SHALL hold its value across program ops and illegal requests.

Reset
REQ-036 rst_n=0 at any edge SHALL force IDLE and outputs cs_n=wr_n=rd_n=1, a1=a0=0, data_out=0, data_oe=0, busy=done=err=0, rd_value=0.
REQ-037 Reset mid-operation aborts with no done pulse and no retry; the first req after rst_n=1 is accepted normally.

Verification
REQ-038 Program chan=0, rw=11, mode=010, bcd=0, count=0x1234 -> writes 0x34@11, 0x34@00, 0x12@00, timing per REQ-034.
REQ-039 Program chan=2, rw=01, count=0x0005 -> two bus cycles (0x92@11, 0x05@10), done 10 clocks after acceptance.
REQ-040 Read chan=1, data_in=0xCD on LSB strobe and 0xAB on MSB strobe -> writes 0x40@11, two rd_n cycles @01, rd_value=0xABCD at done.
REQ-041 chan=3 or op=0 with rw=00 -> single err pulse, cs_n stays 1, busy stays 0.
REQ-042 rst_n=0 during the STROBE of the second byte -> all strobes high on the next clock, busy=0, no done; a fresh request then completes.
REQ-043 WR_WIDTH=1, GAP=0, rw=10 -> 3-clock bus cycles back to back, cs_n continuously low across both cycles.
